// File: rtl/mic1_mem_ctrl.sv
// -----------------------------------------------------------------------------
// mic1_mem_ctrl
//   Memory-port controller for a MIC-1 style microarchitecture. It accepts the
//   word read/write (rd/wr) and byte fetch (fetch) requests issued by the
//   current microinstruction. It turns them into transactions on a single-ported
//   req/ready main-memory handshake. It also stalls the microsequencer until
//   every accepted operation has finished.
//
//   When a data operation and a fetch are accepted together, the data operation
//   is serviced first. The fetch then follows back-to-back.
//
//   Ports
//     clk, resetn             clock; asynchronous active-low reset
//     rd, wr, fetch           request strobes from the microinstruction
//     mar, mdr, pc            current datapath register values
//     stall                   hold MIR/MPC while an operation is outstanding
//     mdr_we, mdr_rdata       one-cycle MDR load strobe and read word
//     mbr_we, mbr_rdata       one-cycle MBR load strobe and fetched byte
//     mem_req, mem_we,        memory request, write enable, word address and
//     mem_addr, mem_wdata     write data; held stable until completion
//     mem_rdata, mem_ready    memory read data and completion handshake
//     err                     sticky error: rd+wr conflict or request timeout
// -----------------------------------------------------------------------------
module mic1_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd,
    input  logic        wr,
    input  logic        fetch,
    input  logic [31:0] mar,
    input  logic [31:0] mdr,
    input  logic [31:0] pc,
    output logic        stall,
    output logic        mdr_we,
    output logic [31:0] mdr_rdata,
    output logic        mbr_we,
    output logic [7:0]  mbr_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH
    } state_t;

    state_t          state;
    logic            fetch_pend;   // a fetch was accepted alongside the data op
    logic            data_is_rd;   // the data op in flight is a read
    logic [29:0]     fetch_word;   // word address of the queued fetch
    logic [1:0]      lane;         // byte lane of the fetch
    logic [CW-1:0]   wait_cnt;

    logic            done;
    logic            expire;
    logic            finish;
    logic            unused_mar_hi;

    // MAR is a word index; its two top bits shift out of the byte address.
    assign unused_mar_hi = ^mar[31:30];

    // mem_req is high exactly while in DATA or FETCH. So done is the only
    // qualification of mem_ready that is needed.
    assign done   = mem_req & mem_ready;
    assign expire = (wait_cnt == CW'(TIMEOUT - 1));
    assign finish = done | expire;

    // Stall comes straight from the state register. It therefore rises on the
    // accepting edge and falls on the edge that finishes the last operation.
    assign stall = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            fetch_pend <= 1'b0;
            data_is_rd <= 1'b0;
            fetch_word <= '0;
            lane       <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mdr_we     <= 1'b0;
            mdr_rdata  <= '0;
            mbr_we     <= 1'b0;
            mbr_rdata  <= '0;
            err        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. The
            // strobes get a default here and are then overridden below. This
            // makes them single-cycle pulses without any extra clearing logic.
            mdr_we <= 1'b0;
            mbr_we <= 1'b0;

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (rd || wr) begin
                        state      <= DATA;
                        mem_req    <= 1'b1;
                        mem_we     <= wr;
                        data_is_rd <= rd && !wr;   // wr wins a rd+wr conflict
                        mem_addr   <= {mar[29:0], 2'b00};
                        mem_wdata  <= mdr;
                        fetch_pend <= fetch;
                        fetch_word <= pc[31:2];
                        lane       <= pc[1:0];
                        if (rd && wr)
                            err <= 1'b1;
                    end else if (fetch) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {pc[31:2], 2'b00};
                        lane     <= pc[1:0];
                    end
                end

                DATA: begin
                    if (finish) begin
                        // A read always loads MDR; on a timeout it loads zero.
                        if (data_is_rd) begin
                            mdr_we    <= 1'b1;
                            mdr_rdata <= done ? mem_rdata : '0;
                        end
                        if (!done)
                            err <= 1'b1;
                        wait_cnt <= '0;
                        mem_we   <= 1'b0;
                        if (fetch_pend) begin
                            // mem_req stays high; only the address changes.
                            state      <= FETCH;
                            mem_addr   <= {fetch_word, 2'b00};
                            fetch_pend <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                FETCH: begin
                    if (finish) begin
                        mbr_we    <= 1'b1;
                        mbr_rdata <= done ? mem_rdata[{lane, 3'b000} +: 8] : '0;
                        if (!done)
                            err <= 1'b1;
                        wait_cnt <= '0;
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mic1_mem_ctrl
//   Scoreboard bench for mic1_mem_ctrl. For each request group, the stimulus
//   side computes the memory transactions it expects and the MDR/MBR loads they
//   must produce. These are pushed into queues. A memory responder pops one
//   transaction descriptor whenever a new request appears. It checks the
//   address, we and wdata, and it answers after the chosen delay. A pulse
//   monitor pops the expected MDR/MBR loads whenever a load strobe appears.
// -----------------------------------------------------------------------------
module tb_mic1_mem_ctrl;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rd, wr, fetch;
    logic [31:0] mar, mdr, pc;
    logic        stall;
    logic        mdr_we, mbr_we;
    logic [31:0] mdr_rdata;
    logic [7:0]  mbr_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    mic1_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd        (rd),
        .wr        (wr),
        .fetch     (fetch),
        .mar       (mar),
        .mdr       (mdr),
        .pc        (pc),
        .stall     (stall),
        .mdr_we    (mdr_we),
        .mdr_rdata (mdr_rdata),
        .mbr_we    (mbr_we),
        .mbr_rdata (mbr_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;    // cycles before mem_ready; >= TIMEOUT never answers
        logic [31:0] rdata;
    } tx_t;

    typedef struct {
        logic [1:0]  kind;     // 2'b10 = MDR load, 2'b01 = MBR load
        logic [31:0] data;
    } pulse_t;

    tx_t    tx_q[$];
    pulse_t pulse_q[$];

    int  tests  = 0;
    int  fails  = 0;
    logic exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles an operation occupies the bus: it completes on the cycle its
    // ready arrives, or it is abandoned after TIMEOUT cycles.
    function automatic int busy_cycles(input int d);
        return (d >= int'(TIMEOUT)) ? int'(TIMEOUT) : d + 1;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        tx_t cur;
        int  cnt;
        bit  in_tx;
        in_tx     = 0;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        cur       = '{addr: '0, we: 1'b0, wdata: '0, delay: 0, rdata: '0};
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_tx     = 0;
                cnt       = 0;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!in_tx) begin
                    if (tx_q.size() == 0) begin
                        check("unexpected_mem_req", {31'b0, mem_req}, 32'h0);
                        cur = '{addr: mem_addr, we: mem_we, wdata: mem_wdata,
                                delay: 0, rdata: '0};
                    end else begin
                        cur = tx_q.pop_front();
                    end
                    in_tx = 1;
                    cnt   = 0;
                end
                check("mem_addr", mem_addr, cur.addr);
                check("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
                if (cur.we)
                    check("mem_wdata", mem_wdata, cur.wdata);
                mem_rdata = cur.rdata;
                mem_ready = (cnt == cur.delay);
                if (cnt == cur.delay || cnt == int'(TIMEOUT) - 1)
                    in_tx = 0;
                else
                    cnt++;
            end else begin
                if (in_tx)
                    check("mem_req_dropped_early", {31'b0, mem_req}, 32'h1);
                in_tx = 0;
                // Ready and data are noise while no request is up.
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- load-pulse monitor ----------------
    initial begin
        pulse_t p;
        forever begin
            @(negedge clk);
            if (resetn && (mdr_we || mbr_we)) begin
                if (pulse_q.size() == 0) begin
                    check("unexpected_load_pulse", {30'b0, mdr_we, mbr_we}, 32'h0);
                end else begin
                    p = pulse_q.pop_front();
                    check("load_kind", {30'b0, mdr_we, mbr_we}, {30'b0, p.kind});
                    if (mdr_we)
                        check("mdr_rdata", mdr_rdata, p.data);
                    else
                        check("mbr_rdata", {24'b0, mbr_rdata}, p.data);
                end
            end
        end
    end

    // Called at a negedge. Presents one request group for one edge, then
    // keeps the bus busy for the predicted number of cycles while throwing
    // ignored requests at the block. It ends at a negedge with the block idle.
    task automatic run_group(input bit r, input bit w, input bit f,
                             input logic [31:0] a_mar, input logic [31:0] a_mdr,
                             input logic [31:0] a_pc,
                             input int d0, input logic [31:0] rd0,
                             input int d1, input logic [31:0] rd1);
        int         busy;
        logic [1:0] last_kind;
        int         lane;
        busy      = 0;
        last_kind = 2'b00;
        if (r || w) begin
            tx_q.push_back('{addr: a_mar << 2, we: w, wdata: a_mdr, delay: d0, rdata: rd0});
            if (r && !w) begin
                pulse_q.push_back('{kind: 2'b10, data: (d0 >= int'(TIMEOUT)) ? 32'h0 : rd0});
                last_kind = 2'b10;
            end else begin
                last_kind = 2'b00;
            end
            if (r && w) exp_err = 1'b1;
            if (d0 >= int'(TIMEOUT)) exp_err = 1'b1;
            busy += busy_cycles(d0);
        end
        if (f) begin
            int          d;
            logic [31:0] rw;
            d    = (r || w) ? d1 : d0;
            rw   = (r || w) ? rd1 : rd0;
            lane = int'(a_pc % 4);
            tx_q.push_back('{addr: a_pc - (a_pc % 4), we: 1'b0, wdata: '0, delay: d, rdata: rw});
            pulse_q.push_back('{kind: 2'b01,
                                data: (d >= int'(TIMEOUT)) ? 32'h0 : ((rw >> (8 * lane)) & 32'hFF)});
            if (d >= int'(TIMEOUT)) exp_err = 1'b1;
            last_kind = 2'b01;
            busy += busy_cycles(d);
        end
        rd = r; wr = w; fetch = f;
        mar = a_mar; mdr = a_mdr; pc = a_pc;
        @(posedge clk);
        repeat (busy) begin
            @(negedge clk);
            check("stall_busy", {31'b0, stall}, 32'h1);
            check("mem_req_busy", {31'b0, mem_req}, 32'h1);
            rd = 1'b1;
            wr = 1'($urandom_range(0, 1));
            fetch = 1'($urandom_range(0, 1));
            mar = $urandom; mdr = $urandom; pc = $urandom;
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; fetch = 1'b0;
        check("stall_idle", {31'b0, stall}, 32'h0);
        check("mem_req_idle", {31'b0, mem_req}, 32'h0);
        check("final_load_strobe", {30'b0, mdr_we, mbr_we}, {30'b0, last_kind});
        check("err", {31'b0, err}, {31'b0, exp_err});
        @(negedge clk);
        check("strobe_one_cycle", {30'b0, mdr_we, mbr_we}, 32'h0);
        check("stall_after", {31'b0, stall}, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        exp_err = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        rd = 1'b0; wr = 1'b0; fetch = 1'b0;
        mar = '0; mdr = '0; pc = '0;
        #1;
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_mem_req", {31'b0, mem_req}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mdr_rdata", mdr_rdata, 32'h0);
        check("reset_mbr_rdata", {24'b0, mbr_rdata}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Word read, memory answers at once: addr 0x40, one stall cycle.
        run_group(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0);
        // Byte fetch from lane 3 of word 0x100.
        run_group(0, 0, 1, 32'h0, 32'h0, 32'h103, 0, 32'hAABBCCDD, 0, 32'h0);
        // Write then fetch accepted together, both at address 4.
        run_group(0, 1, 1, 32'h1, 32'h12345678, 32'h4, 0, 32'h0, 0, 32'h11223344);
        // Read with ready delayed three cycles; rd is re-asserted while stalled.
        run_group(1, 0, 0, 32'h25, 32'h0, 32'h0, 3, 32'hCAFEF00D, 0, 32'h0);
        // Read that is never answered: abort after TIMEOUT cycles, zero data.
        run_group(1, 0, 0, 32'h7, 32'h0, 32'h0, 1000, 32'h0, 0, 32'h0);
        repeat (3) @(negedge clk);
        check("err_sticky", {31'b0, err}, 32'h1);

        // Reset asserted in the middle of an unanswered read.
        tx_q.push_back('{addr: 32'h80, we: 1'b0, wdata: '0, delay: 1000, rdata: '0});
        rd = 1'b1; mar = 32'h20;
        @(posedge clk);
        #1 rd = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midreset_mem_req", {31'b0, mem_req}, 32'h0);
        check("midreset_stall", {31'b0, stall}, 32'h0);
        check("midreset_err", {31'b0, err}, 32'h0);
        check("midreset_mdr_we", {31'b0, mdr_we}, 32'h0);
        check("midreset_mem_addr", mem_addr, 32'h0);
        exp_err = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        // Accepted on the first edge after release.
        run_group(1, 0, 0, 32'h30, 32'h0, 32'h0, 0, 32'h0BADF00D, 0, 32'h0);

        // Randomized groups.
        apply_reset();
        for (int g = 0; g < 150; g++) begin
            bit          r, w, f;
            int          dl[2];
            logic [31:0] dw[2];
            int unsigned ops;
            ops = $urandom_range(1, 7);
            r = ops[0]; w = ops[1]; f = ops[2];
            if (r && w && $urandom_range(0, 7) != 0) r = 1'b0;
            for (int k = 0; k < 2; k++) begin
                int unsigned sel;
                sel   = $urandom_range(0, 15);
                dl[k] = (sel < 10) ? int'(sel % 4) :
                        (sel < 12) ? int'(TIMEOUT) - 1 :
                        (sel < 13) ? int'(TIMEOUT) + 3 : 0;
                dw[k] = $urandom;
            end
            run_group(r, w, f, $urandom, $urandom, $urandom, dl[0], dw[0], dl[1], dw[1]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("tx_queue_drained", tx_q.size(), 32'h0);
        check("pulse_queue_drained", pulse_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
